mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_bist.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// -----------------------------------------------------------------------------
// mem_bist : single-port memory built-in self test controller.
//
// One run writes a pattern to every location (ascending), then reads each
// location back and compares it with the same pattern. The run length is
// 3*DEPTH cycles: one WRITE cycle per address, then a READ/CHECK pair per
// address.
//
// Parameters
//   ADDR_W  memory address width, DEPTH = 2**ADDR_W
//   DATA_W  memory data width (2..64)
//   ERR_W   width of the saturating mismatch counter
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      level; accepted only in IDLE or DONE
//   mode       pattern: 0 zeros, 1 address, 2 checkerboard, 3 ~address
//   read       memory read strobe (registered)
//   write      memory write strobe (registered)
//   addr       memory address (registered)
//   data_in    memory write data (registered)
//   data_out   memory read data, sampled on the edge ending the read cycle
//   busy       run in progress
//   done       run finished, held until the next accepted start
//   pass       1 while done and no mismatches were seen
//   err_count  saturating mismatch count of the current/last run
//   fail_addr  address of the first mismatch
//   fail_data  data read at the first mismatch
//
// Configuration
//   MEM_BIST_ERRLOG_EN  when defined, fail_addr/fail_data capture the first
//                       mismatch of a run; otherwise both are tied to zero.
// -----------------------------------------------------------------------------
module mem_bist #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  // Pattern value for address a under mode m. The checkerboard starts with
  // LSB 1 on even addresses and inverts on odd ones, which also covers odd
  // DATA_W without a special case.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] as_data;
    logic [DATA_W-1:0] chk;
    as_data = DATA_W'(a);
    for (int i = 0; i < DATA_W; i++) begin
      chk[i] = (i % 2 == 0) ? ~a[0] : a[0];
    end
    case (m)
      2'd0:    return '0;
      2'd1:    return as_data;
      2'd2:    return chk;
      default: return ~as_data;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] addr_inc;
  logic              mismatch;

  assign addr_inc = addr_q + 1'b1;

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so they can all leave the block straight from flops.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    addr_d    = addr_q;
    data_in_d = '0;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    rd_d      = rd_q;
    mismatch  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // The first write is issued on the accepting edge, so the incoming
          // mode is used directly rather than the not-yet-latched copy.
          state_d   = ST_WRITE;
          mode_d    = mode;
          write_d   = 1'b1;
          addr_d    = '0;
          data_in_d = pattern(mode, '0);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = '0;
        end
      end

      ST_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_READ;
          addr_d  = '0;
          read_d  = 1'b1;
        end else begin
          addr_d    = addr_inc;
          write_d   = 1'b1;
          data_in_d = pattern(mode_q, addr_inc);
        end
      end

      ST_READ: begin
        // Read data is valid on the edge that ends the read cycle.
        state_d = ST_CHECK;
        rd_d    = data_out;
      end

      ST_CHECK: begin
        mismatch = (rd_q != pattern(mode_q, addr_q));
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + 1'b1;
        end
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
          addr_d  = addr_inc;
          read_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 2'd0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
    end
  end

  assign read      = read_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign data_in   = data_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign pass      = done_q & (err_q == '0);

`ifdef MEM_BIST_ERRLOG_EN
  logic              run_start;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;

  assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // A zero error count at compare time means this is the first mismatch of
  // the run; the counter never returns to zero within a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (run_start) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (mismatch && (err_q == '0)) begin
      fail_addr_q <= addr_q;
      fail_data_q <= rd_q;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_mem_bist.sv
// -----------------------------------------------------------------------------
// tb_mem_bist : self-checking bench for mem_bist.
// Two instances: A uses default parameters (8-bit data, 32 words);
// B uses ADDR_W=4, DATA_W=16, ERR_W=4 for wide checkerboard and counter
// saturation. Each instance talks to a small memory model that can inject
// faults. Expected write transactions, read addresses and run results are
// queued when a run is started and consumed as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_mem_bist;

  localparam int AW_A = 5, DW_A = 8,  EW_A = 8;
  localparam int AW_B = 4, DW_B = 16, EW_B = 4;
  localparam int DEPTH_A = 1 << AW_A;
  localparam int DEPTH_B = 1 << AW_B;

`ifdef MEM_BIST_ERRLOG_EN
  localparam bit ERRLOG = 1'b1;
`else
  localparam bit ERRLOG = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals
  logic            start_a, read_a, write_a, busy_a, done_a, pass_a;
  logic [1:0]      mode_a;
  logic [AW_A-1:0] addr_a, fail_addr_a;
  logic [DW_A-1:0] data_in_a, data_out_a, fail_data_a;
  logic [EW_A-1:0] err_a;
  // Instance B signals
  logic            start_b, read_b, write_b, busy_b, done_b, pass_b;
  logic [1:0]      mode_b;
  logic [AW_B-1:0] addr_b, fail_addr_b;
  logic [DW_B-1:0] data_in_b, data_out_b, fail_data_b;
  logic [EW_B-1:0] err_b;

  mem_bist #(.ADDR_W(AW_A), .DATA_W(DW_A), .ERR_W(EW_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .read(read_a), .write(write_a), .addr(addr_a), .data_in(data_in_a),
    .data_out(data_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_addr(fail_addr_a), .fail_data(fail_data_a)
  );

  mem_bist #(.ADDR_W(AW_B), .DATA_W(DW_B), .ERR_W(EW_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
    .read(read_b), .write(write_b), .addr(addr_b), .data_in(data_in_b),
    .data_out(data_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_addr(fail_addr_b), .fail_data(fail_data_b)
  );

  // Memory models: A can force bit 3 high at address 5, B can read all-ones.
  logic [DW_A-1:0] mem_a [DEPTH_A];
  logic [DW_B-1:0] mem_b [DEPTH_B];
  logic            stuck_a = 1'b0;
  logic            ones_b  = 1'b0;

  always @(posedge clk) begin
    if (write_a) mem_a[addr_a] <= data_in_a;
    if (write_b) mem_b[addr_b] <= data_in_b;
  end

  assign data_out_a = mem_a[addr_a] | ((stuck_a && addr_a == 5'd5) ? 8'h08 : 8'h00);
  assign data_out_b = ones_b ? 16'hFFFF : mem_b[addr_b];

  // Scoreboard storage
  typedef struct { int a; logic [63:0] d; } wr_t;
  typedef struct { int err; logic [63:0] fa; logic [63:0] fd; } res_t;
  wr_t  wq_a[$], wq_b[$];
  int   rq_a[$], rq_b[$];
  res_t xq_a[$], xq_b[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tb_pat(input logic [1:0] m, input int a, input int w);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (m)
      2'd0:    v = 64'd0;
      2'd1:    v = 64'(a);
      2'd2:    v = a[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      default: v = ~64'(a);
    endcase
    return v & mask;
  endfunction

  // Bus monitors: compare every strobe against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_a) begin
        wr_t e;
        check("a_rw_excl", 64'(read_a), 64'd0);
        if (wq_a.size() == 0) check("a_wr_extra", 64'(write_a), 64'd0);
        else begin
          e = wq_a.pop_front();
          check("a_wr_addr", 64'(addr_a), 64'(e.a));
          check("a_wr_data", 64'(data_in_a), e.d);
        end
      end
      if (read_a) begin
        if (rq_a.size() == 0) check("a_rd_extra", 64'(read_a), 64'd0);
        else check("a_rd_addr", 64'(addr_a), 64'(rq_a.pop_front()));
      end
      if (write_b) begin
        wr_t e;
        check("b_rw_excl", 64'(read_b), 64'd0);
        if (wq_b.size() == 0) check("b_wr_extra", 64'(write_b), 64'd0);
        else begin
          e = wq_b.pop_front();
          check("b_wr_addr", 64'(addr_b), 64'(e.a));
          check("b_wr_data", 64'(data_in_b), e.d);
        end
      end
      if (read_b) begin
        if (rq_b.size() == 0) check("b_rd_extra", 64'(read_b), 64'd0);
        else check("b_rd_addr", 64'(addr_b), 64'(rq_b.pop_front()));
      end
    end
  end

  task automatic push_exp_a(input logic [1:0] m);
    for (int a = 0; a < DEPTH_A; a++) begin
      wq_a.push_back('{a, tb_pat(m, a, DW_A)});
      rq_a.push_back(a);
    end
  endtask

  // Called right after a falling edge. glitch_at>0 pulses start for one
  // cycle mid-run; keep=1 leaves start high after the run ends.
  task automatic run_a(input logic [1:0] m, input logic keep, input int glitch_at,
                       input int exp_err, input int exp_fa, input logic [63:0] exp_fd);
    res_t r;
    int   n;
    int   busy_n;
    push_exp_a(m);
    xq_a.push_back('{exp_err, 64'(exp_fa), exp_fd});
    mode_a  = m;
    start_a = 1'b1;
    @(negedge clk);
    if (!keep) start_a = 1'b0;
    mode_a = ~m;
    check("a_busy_rise", 64'(busy_a), 64'd1);
    check("a_done_fall", 64'(done_a), 64'd0);
    check("a_pass_low",  64'(pass_a), 64'd0);
    check("a_err_clr",   64'(err_a),  64'd0);
    check("a_fa_clr",    64'(fail_addr_a), 64'd0);
    n = 0;
    busy_n = 0;
    while (!done_a && n < 4 * DEPTH_A) begin
      if (busy_a) busy_n++;
      @(negedge clk);
      n++;
      if (n == glitch_at) start_a = 1'b1;
      else if (n == glitch_at + 1 && !keep) start_a = 1'b0;
    end
    r = xq_a.pop_front();
    check("a_done_time", 64'(n), 64'(3 * DEPTH_A));
    check("a_busy_len",  64'(busy_n), 64'(3 * DEPTH_A));
    check("a_busy_fall", 64'(busy_a), 64'd0);
    check("a_err",       64'(err_a), 64'(r.err));
    check("a_pass",      64'(pass_a), 64'(r.err == 0));
    check("a_fail_addr", 64'(fail_addr_a), ERRLOG ? r.fa : 64'd0);
    check("a_fail_data", 64'(fail_data_a), ERRLOG ? r.fd : 64'd0);
    check("a_wr_left",   64'(wq_a.size()), 64'd0);
    check("a_rd_left",   64'(rq_a.size()), 64'd0);
  endtask

  task automatic run_b(input logic [1:0] m, input int exp_err,
                       input int exp_fa, input logic [63:0] exp_fd);
    res_t r;
    int   n;
    for (int a = 0; a < DEPTH_B; a++) begin
      wq_b.push_back('{a, tb_pat(m, a, DW_B)});
      rq_b.push_back(a);
    end
    xq_b.push_back('{exp_err, 64'(exp_fa), exp_fd});
    mode_b  = m;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_busy_rise", 64'(busy_b), 64'd1);
    n = 0;
    while (!done_b && n < 4 * DEPTH_B) begin
      @(negedge clk);
      n++;
    end
    r = xq_b.pop_front();
    check("b_done_time", 64'(n), 64'(3 * DEPTH_B));
    check("b_err",       64'(err_b), 64'(r.err));
    check("b_pass",      64'(pass_b), 64'(r.err == 0));
    check("b_fail_addr", 64'(fail_addr_b), ERRLOG ? r.fa : 64'd0);
    check("b_fail_data", 64'(fail_data_b), ERRLOG ? r.fd : 64'd0);
    check("b_wr_left",   64'(wq_b.size()), 64'd0);
    check("b_rd_left",   64'(rq_b.size()), 64'd0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_read"},  64'(read_a),      64'd0);
    check({tag, "_write"}, 64'(write_a),     64'd0);
    check({tag, "_addr"},  64'(addr_a),      64'd0);
    check({tag, "_din"},   64'(data_in_a),   64'd0);
    check({tag, "_busy"},  64'(busy_a),      64'd0);
    check({tag, "_done"},  64'(done_a),      64'd0);
    check({tag, "_pass"},  64'(pass_a),      64'd0);
    check({tag, "_err"},   64'(err_a),       64'd0);
    check({tag, "_fa"},    64'(fail_addr_a), 64'd0);
    check({tag, "_fd"},    64'(fail_data_a), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    start_a = 1'b0; mode_a = 2'd0;
    start_b = 1'b0; mode_b = 2'd0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_a("rst");
    check("rst_b_busy", 64'(busy_b), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Start accepted on the first edge after reset release.
    run_a(2'd0, 1'b0, 0, 0, 0, 64'd0);
    // Bit 3 stuck high at address 5.
    stuck_a = 1'b1;
    run_a(2'd1, 1'b0, 0, 1, 5, 64'h0D);
    // The stuck bit is already 1 in these patterns at address 5.
    run_a(2'd2, 1'b0, 0, 0, 0, 64'd0);
    run_a(2'd3, 1'b0, 0, 0, 0, 64'd0);
    stuck_a = 1'b0;
    // Start pulsed mid-run must not disturb timing.
    run_a(2'd1, 1'b0, 10, 0, 0, 64'd0);
    // Start held through DONE: back-to-back runs.
    run_a(2'd0, 1'b1, 0, 0, 0, 64'd0);
    run_a(2'd2, 1'b0, 0, 0, 0, 64'd0);

    // Reset in the middle of a run.
    push_exp_a(2'd1);
    mode_a  = 2'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_a("midrst");
    wq_a.delete();
    rq_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_a(2'd1, 1'b0, 0, 0, 0, 64'd0);

    // Wide checkerboard, then counter saturation (16 mismatches, max 15).
    run_b(2'd2, 0, 0, 64'd0);
    ones_b = 1'b1;
    run_b(2'd0, 15, 0, 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
